// File: rtl/riscv_pkg.sv
// Shared execute-stage types for the RV32M multiply/divide unit: funct3 encodings,
// the execute result-select code for muldiv and the unit's FSM states.
package riscv_pkg;

   typedef enum logic [2:0] {
      FUNC_MUL    = 3'd0,
      FUNC_MULH   = 3'd1,
      FUNC_MULHSU = 3'd2,
      FUNC_MULHU  = 3'd3,
      FUNC_DIV    = 3'd4,
      FUNC_DIVU   = 3'd5,
      FUNC_REM    = 3'd6,
      FUNC_REMU   = 3'd7
   } muldiv_func_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_CALC,
      ST_DONE
   } muldiv_state_t;

   // exec_sel code that routes the execute result mux to this unit
   localparam logic [2:0] EXEC_SEL_MULDIV = 3'd3;

   function automatic logic func_is_div(input muldiv_func_t f);
      return f inside {FUNC_DIV, FUNC_DIVU, FUNC_REM, FUNC_REMU};
   endfunction

   function automatic logic func_a_signed(input muldiv_func_t f);
      return f inside {FUNC_MULH, FUNC_MULHSU, FUNC_DIV, FUNC_REM};
   endfunction

   function automatic logic func_b_signed(input muldiv_func_t f);
      return f inside {FUNC_MULH, FUNC_DIV, FUNC_REM};
   endfunction

endpackage

// File: rtl/exec_muldiv_unit_if.sv
// Execute-stage handshake between the pipeline (master) and the muldiv unit (slave).
interface exec_muldiv_unit_if #(
   parameter int XLEN = 32
);
   import riscv_pkg::*;

   logic             start;
   logic             flush;
   muldiv_func_t     func;
   logic [XLEN-1:0]  op_a;
   logic [XLEN-1:0]  op_b;
   logic             busy;
   logic             done;
   logic [XLEN-1:0]  result;

   modport master (
      output start, flush, func, op_a, op_b,
      input  busy, done, result
   );

   modport slave (
      input  start, flush, func, op_a, op_b,
      output busy, done, result
   );

endinterface

// File: rtl/exec_muldiv_unit_muldiv_core.sv
// Iterative datapath: one shift-add multiply step or one restoring divide step per cycle
// on a shared 2*XLEN accumulator {hi, lo}.
module muldiv_core #(
   parameter int XLEN = 32
) (
   input  logic              clk,
   input  logic              load,
   input  logic              step,
   input  logic              is_div,
   input  logic [XLEN-1:0]   load_lo,
   input  logic [XLEN-1:0]   load_oper,
   output logic [2*XLEN-1:0] acc_next
);

   logic [2*XLEN-1:0] acc;
   logic [XLEN-1:0]   oper;
   logic              div_mode;

   logic [XLEN-1:0]   hi;
   logic [XLEN-1:0]   lo;
   logic [XLEN:0]     mul_sum;
   logic [XLEN:0]     shifted;
   logic [XLEN-1:0]   trial;
   logic              fits;

   assign hi = acc[2*XLEN-1:XLEN];
   assign lo = acc[XLEN-1:0];

   // Multiply: hi holds the partial product, lo the remaining multiplier bits.
   assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, oper} : '0);

   // Divide: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
   // When the trial subtract succeeds the true difference is below the divisor, so the
   // low XLEN bits of the modular subtract are exact.
   assign shifted = {hi, lo[XLEN-1]};
   assign fits    = shifted >= {1'b0, oper};
   assign trial   = shifted[XLEN-1:0] - oper;

   // NOTE: every variable driven from always_comb gets a value on every path, so no latch is inferred.
   always_comb begin
      acc_next = {mul_sum, lo[XLEN-1:1]};
      if (div_mode) begin
         acc_next = {(fits ? trial : shifted[XLEN-1:0]), lo[XLEN-2:0], fits};
      end
   end

   // NOTE: datapath registers carry no reset; they are always loaded before their value is used.
   always_ff @(posedge clk) begin
      if (load) begin
         acc      <= {{XLEN{1'b0}}, load_lo};
         oper     <= load_oper;
         div_mode <= is_div;
      end else if (step) begin
         acc <= acc_next;
      end
   end

endmodule

// File: rtl/exec_muldiv_unit.sv
// RV32M multiply/divide unit: FSM, counter, sign handling and result selection around
// the iterative muldiv_core; stalls the pipeline via busy and pulses done with the result.
module exec_muldiv_unit
   import riscv_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int CNT_W = $clog2(XLEN)
) (
   input  logic             clk,
   input  logic             reset,
   exec_muldiv_unit_if.slave bus
);

   localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

   muldiv_state_t     state;
   logic [CNT_W-1:0]  cnt;
   muldiv_func_t      func_q;
   logic              neg_q;
   logic              done_q;
   logic [XLEN-1:0]   result_q;

   logic              accept;
   logic              is_div_op;
   logic              a_neg;
   logic              b_neg;
   logic              neg_in;
   logic [XLEN-1:0]   a_abs;
   logic [XLEN-1:0]   b_abs;
   logic              div_zero;
   logic              div_ovf;
   logic              special;
   logic [XLEN-1:0]   special_result;
   logic [2*XLEN-1:0] acc_next;
   logic [2*XLEN-1:0] prod_fixed;
   logic [XLEN-1:0]   quo;
   logic [XLEN-1:0]   rem;
   logic [XLEN-1:0]   final_result;

   assign accept    = (state == ST_IDLE) && bus.start && !bus.flush;
   assign is_div_op = func_is_div(bus.func);
   assign a_neg     = func_a_signed(bus.func) && bus.op_a[XLEN-1];
   assign b_neg     = func_b_signed(bus.func) && bus.op_b[XLEN-1];
   // Remainder follows the dividend; quotient and product follow the sign difference.
   assign neg_in    = (bus.func == FUNC_REM) ? a_neg : (a_neg ^ b_neg);
   assign a_abs     = a_neg ? -bus.op_a : bus.op_a;
   assign b_abs     = b_neg ? -bus.op_b : bus.op_b;

   assign div_zero = is_div_op && (bus.op_b == '0);
   assign div_ovf  = (bus.func == FUNC_DIV || bus.func == FUNC_REM) &&
                     (bus.op_a == MIN_INT) && (bus.op_b == '1);
   assign special  = div_zero || div_ovf;

   always_comb begin
      special_result = '0;
      if (div_zero) begin
         special_result = (bus.func == FUNC_DIV || bus.func == FUNC_DIVU) ? '1 : bus.op_a;
      end else if (bus.func == FUNC_DIV) begin
         special_result = MIN_INT;
      end
   end

   muldiv_core #(.XLEN(XLEN)) u_core (
      .clk       (clk),
      .load      (accept),
      .step      (state == ST_CALC),
      .is_div    (is_div_op),
      .load_lo   (is_div_op ? a_abs : b_abs),
      .load_oper (is_div_op ? b_abs : a_abs),
      .acc_next  (acc_next)
   );

   // Final-iteration value with sign fix-up; the full product is negated before a half is picked.
   assign prod_fixed = neg_q ? -acc_next : acc_next;
   assign quo        = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
   assign rem        = neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];

   always_comb begin
      case (func_q)
         FUNC_MUL:                            final_result = prod_fixed[XLEN-1:0];
         FUNC_MULH, FUNC_MULHSU, FUNC_MULHU:  final_result = prod_fixed[2*XLEN-1:XLEN];
         FUNC_DIV, FUNC_DIVU:                 final_result = quo;
         default:                             final_result = rem;
      endcase
   end

   // NOTE: all state below is sequential and assigned with <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         func_q   <= FUNC_MUL;
         neg_q    <= 1'b0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (bus.flush) begin
            state <= ST_IDLE;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (bus.start) begin
                     func_q <= bus.func;
                     neg_q  <= neg_in;
                     cnt    <= CNT_W'(XLEN - 1);
                     if (special) begin
                        result_q <= special_result;
                        done_q   <= 1'b1;
                        state    <= ST_DONE;
                     end else begin
                        state <= ST_CALC;
                     end
                  end
               end
               ST_CALC: begin
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == '0) begin
                     result_q <= final_result;
                     done_q   <= 1'b1;
                     state    <= ST_DONE;
                  end
               end
               // The instruction that just finished is still held in E, so start is ignored here.
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

   assign bus.busy   = (accept || state == ST_CALC) && !bus.flush;
   assign bus.done   = done_q && !bus.flush;
   assign bus.result = result_q;

endmodule

// File: tb/tb_exec_muldiv_unit.sv
// Directed bench for exec_muldiv_unit: an arithmetic reference model sets the expected
// result and done cycle of each operation; a negedge process compares busy/done/result.
module tb_exec_muldiv_unit;
   import riscv_pkg::*;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   exec_muldiv_unit_if #(.XLEN(32)) bus ();

   exec_muldiv_unit #(.XLEN(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;
   int done_seen = 0;
   int done_exp  = 0;

   logic        m_active = 1'b0;
   int          m_start  = 0;
   int          m_done   = 0;
   logic [31:0] m_result = '0;
   logic        exp_busy;
   logic        exp_done;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic is_special(input muldiv_func_t f, input logic [31:0] a, input logic [31:0] b);
      return (f inside {FUNC_DIV, FUNC_DIVU, FUNC_REM, FUNC_REMU}) &&
             (b == 32'd0 || ((f == FUNC_DIV || f == FUNC_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
   endfunction

   function automatic logic [31:0] model(input muldiv_func_t f, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] sa, sb, ua, ub, p;
      logic        ovf;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      ua  = {32'd0, a};
      ub  = {32'd0, b};
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      case (f)
         FUNC_MUL:    begin p = ua * ub; return p[31:0];  end
         FUNC_MULH:   begin p = sa * sb; return p[63:32]; end
         FUNC_MULHSU: begin p = sa * ub; return p[63:32]; end
         FUNC_MULHU:  begin p = ua * ub; return p[63:32]; end
         FUNC_DIV:    return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'($signed(a) / $signed(b));
         FUNC_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
         FUNC_REM:    return (b == 0) ? a : ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         default:     return (b == 0) ? a : a % b;
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (!reset) begin
         exp_busy = m_active && (cyc >= m_start) && (cyc < m_done) && !bus.flush;
         exp_done = m_active && (cyc == m_done) && !bus.flush;
         check("busy", {31'd0, bus.busy}, {31'd0, exp_busy});
         check("done", {31'd0, bus.done}, {31'd0, exp_done});
         if (exp_done) check("result", bus.result, m_result);
         if (bus.done) done_seen++;
      end
   end

   // Issue one op at posedge+1 and keep start high through its done cycle.
   task automatic issue(input muldiv_func_t f, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] lit, input string name);
      logic [31:0] e;
      e = model(f, a, b);
      check({name, "_model"}, e, lit);
      bus.start = 1'b1;
      bus.func  = f;
      bus.op_a  = a;
      bus.op_b  = b;
      m_active  = 1'b1;
      m_start   = cyc;
      m_done    = cyc + (is_special(f, a, b) ? 1 : 33);
      m_result  = e;
      done_exp++;
      while (cyc <= m_done) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int n);
      bus.start = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      bus.start = 1'b0;
      bus.flush = 1'b0;
      bus.func  = FUNC_MUL;
      bus.op_a  = '0;
      bus.op_b  = '0;
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      check("reset_result", bus.result, 32'd0);
      idle(2);

      issue(FUNC_MUL,    32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3");
      idle(1);
      issue(FUNC_MULH,   32'h8000_0000,  32'h8000_0000, 32'h4000_0000, "mulh_min");
      issue(FUNC_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_max");
      issue(FUNC_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_max");
      issue(FUNC_MULHU,  32'hFFFF_FFFF,  32'd2,         32'd1,         "mulhu_carry");
      issue(FUNC_MUL,    32'h0001_0000,  32'h0001_0000, 32'd0,         "mul_wrap");
      issue(FUNC_DIV,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, "div_m7_2");
      issue(FUNC_REM,    32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, "rem_m7_2");
      issue(FUNC_DIV,    32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, "div_7_m2");
      issue(FUNC_REM,    32'd7,          32'hFFFF_FFFE, 32'd1,         "rem_7_m2");
      issue(FUNC_REMU,   32'd100,        32'd7,         32'd2,         "remu_100_7");
      issue(FUNC_DIV,    32'd5,          32'd0,         32'hFFFF_FFFF, "div_by_0");
      issue(FUNC_REM,    32'd5,          32'd0,         32'd5,         "rem_by_0");
      issue(FUNC_DIVU,   32'd5,          32'd0,         32'hFFFF_FFFF, "divu_by_0");
      issue(FUNC_DIV,    32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
      issue(FUNC_REM,    32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "rem_ovf");
      issue(FUNC_DIVU,   32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         "divu_nonovf");
      issue(FUNC_REMU,   32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, "remu_nonovf");
      issue(FUNC_DIVU,   32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, "divu_by_1");
      idle(2);

      // Back-to-back: start stays high through DONE, next op the following cycle.
      issue(FUNC_DIVU,   32'd100,        32'd7,         32'd14,        "divu_100_7");
      issue(FUNC_DIVU,   32'd9,          32'd3,         32'd3,         "divu_9_3");
      idle(3);

      // Flush on the 10th CALC cycle: busy drops that cycle, no done afterwards.
      bus.start = 1'b1;
      bus.func  = FUNC_MUL;
      bus.op_a  = 32'd3;
      bus.op_b  = 32'd4;
      m_active  = 1'b1;
      m_start   = cyc;
      m_done    = cyc + 33;
      m_result  = 32'd12;
      while (cyc < m_start + 10) begin
         @(posedge clk);
         #1;
      end
      bus.flush = 1'b1;
      @(posedge clk);
      #1;
      bus.flush = 1'b0;
      bus.start = 1'b0;
      m_active  = 1'b0;
      idle(40);

      // Synchronous reset mid-CALC aborts with all outputs cleared.
      issue(FUNC_MULHU, 32'hFFFF_FFFF, 32'd2, 32'd1, "mulhu_pre_reset");
      bus.start = 1'b1;
      bus.func  = FUNC_DIVU;
      bus.op_a  = 32'd1000;
      bus.op_b  = 32'd10;
      m_active  = 1'b1;
      m_start   = cyc;
      m_done    = cyc + 33;
      m_result  = 32'd100;
      repeat (10) begin
         @(posedge clk);
         #1;
      end
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset     = 1'b0;
      bus.start = 1'b0;
      m_active  = 1'b0;
      check("reset_mid_result", bus.result, 32'd0);
      idle(40);

      check("done_count", done_seen, done_exp);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/exec_muldiv_unit.md
Name: exec_muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage.
- Consumes the decode/execute register outputs: operands, function and a start qualifier derived from exec_sel/rd_valid.
- Holds the pipeline via busy (fed into the hazard/halt logic) while it computes, then presents a one-cycle result to the execute result mux.
- Shift-add multiply and restoring divide, one bit per cycle.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, $clog2(XLEN), iteration counter width.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  valid M-extension instruction in execute this cycle
- flush  input  1  squash the execute stage (branch/jump redirect)
- func  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- op_a  input  XLEN  rs1 value (already forwarded)
- op_b  input  XLEN  rs2 value (already forwarded)
- busy  output  1  stall request; pipeline must hold D/E register and upstream
- done  output  1  result valid this cycle; pipeline may advance
- result  output  XLEN  result; valid when done

Behaviour:
- Clock, reset: clock is clk; reset is synchronous and active-high, named reset.
- Reset: state IDLE; counter 0; result 0; done 0; busy 0. Reset mid-operation aborts the computation with no done pulse.
- States: IDLE, CALC, DONE (muldiv_state_t).
- IDLE, on start && !flush:
  - Latch |op_a| and |op_b| per signedness: MULH/DIV/REM both signed; MULHSU op_a signed only; others unsigned.
  - Latch func and the result-negate flag. Quotient negates if signs differ; remainder takes the dividend sign; product negates if the signs of the signed operands differ.
  - Load counter = XLEN-1.
  - Divide special cases go IDLE->DONE directly:
    - op_b==0: quotient all-ones; remainder = op_a.
    - Signed op_a==0x80000000, op_b==0xFFFFFFFF: DIV result 0x80000000; REM result 0.
  - All other cases go to CALC.
- busy: combinational. busy = (IDLE && start && !flush) || CALC. It is low in DONE.
- CALC:
  - Multiply: 2*XLEN-bit accumulator shift-add on one multiplier bit per cycle.
  - Divide: restoring step per cycle (shift remainder, trial subtract, set quotient bit).
  - Counter decrements each cycle. Counter==0 -> DONE after its final iteration.
  - Exactly XLEN CALC cycles.
- DONE:
  - done=1 for exactly one cycle. result is the registered final value after sign fix-up; 64-bit product negated before selecting the half.
  - MUL selects the low word; MULH/MULHSU/MULHU select the high word; DIV/DIVU select the quotient; REM/REMU select the remainder.
  - Next state is IDLE unconditionally. start is ignored in DONE because the same instruction is still held in E.
- Latency: normal op occupies execute for XLEN+2 cycles (accept + 32 CALC + DONE = 34). Special-case divide takes 2 cycles.
- result holds its value after DONE until the next result is written; it is don't-care unless done is high.
- flush has priority over start in every state: forces IDLE next cycle, suppresses done, and forces busy low that cycle.
- A start in the cycle after DONE begins a new operation. Back-to-back M instructions are therefore legal without bubbles beyond the unit latency.
- start is low when exec_sel does not select muldiv: the unit stays IDLE and outputs are inert.
- No arithmetic overflow beyond the cases above. All internal widths: accumulator 2*XLEN, remainder XLEN+1 for the trial subtract.

Decomposition:
- Shared package (riscv_pkg): muldiv_func_t enum for funct3 encodings; exec_sel encoding constant for MULDIV; muldiv_state_t enum.
- One sub-module: muldiv_core. Holds the iterative datapath (accumulator, remainder/quotient registers, one-step add/subtract). It is controlled by the FSM and counter in exec_muldiv_unit.
- Sign handling and result selection stay in the top module.

Test Plan:
- MUL 7 x -3 (op_a=7, op_b=0xFFFFFFFD) -> busy 33 cycles from start, done pulse on cycle 34, result 0xFFFFFFEB.
- MULH 0x80000000 x 0x80000000 -> result 0x40000000. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- DIV 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with done on the 2nd cycle. DIV 0x80000000/-1 -> 0x80000000 and REM -> 0, both in 2 cycles.
- start held through DONE, then a second DIVU 9/3 started the next cycle -> exactly two done pulses, results 14 then 3. No spurious restart.
- flush at CALC cycle 10 -> busy low next cycle, no done, state IDLE. Reset asserted mid-CALC -> all outputs 0 next cycle, no done.
